lpc_host: RTL and testbench

//  LPC bus initiator: turns one request (I/O read or write, 16-bit address, 8-bit data) into a complete LPC I/O cycle.
//  It drives LPC_FRAME and LAD, samples the peripheral's SYNC and read data, and returns one response per request.

---
 rtl/lpc_pkg.sv | 29 ++
 rtl/lpc_host.sv | 221 ++++++++++++++++++++++
 tb/tb_lpc_host.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lpc_pkg.sv
// Shared LPC definitions (START/CYCTYPE/SYNC nibble codes and the cycle state
// enum) used by both the host initiator and the target side.
package lpc_pkg;

  localparam logic [3:0] LPC_START       = 4'b0000;
  localparam logic [3:0] CYC_IO_RD       = 4'b0000;
  localparam logic [3:0] CYC_IO_WR       = 4'b0010;
  localparam logic [3:0] SYNC_READY      = 4'b0000;
  localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
  localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
  localparam logic [3:0] SYNC_ERROR      = 4'b1010;
  localparam logic [3:0] LAD_IDLE        = 4'b1111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CYC,
    ST_ADDR,
    ST_WDATA,
    ST_TAR1,
    ST_TAR2,
    ST_SYNC,
    ST_RDATA,
    ST_PTAR,
    ST_ABORT,
    ST_ABORT_END
  } lpc_state_e;

endpackage

// File: rtl/lpc_host.sv
// LPC I/O-cycle initiator: one request in, one LPC I/O read/write cycle on the
// bus, one response out. Optional abort frame on SYNC timeout: LPC_HOST_ABORT_EN.
module lpc_host
  import lpc_pkg::*;
#(
  parameter int SYNC_TIMEOUT = 8
) (
  input  logic        LPC_CLK,
  input  logic        LPC_RST,
  output logic        LPC_FRAME,
  output logic [3:0]  LAD_O,
  output logic        LAD_OE,
  input  logic [3:0]  LAD_I,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_error
);

  localparam int CW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(SYNC_TIMEOUT);

  lpc_state_e    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          wr_q, wr_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          frame_q, frame_d;
  logic [3:0]    lad_o_q, lad_o_d;
  logic          lad_oe_q, lad_oe_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_error_q, rsp_error_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + CW'(1);
    wr_d        = wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;

    case (state_q)
      ST_IDLE: if (req_valid) begin
        wr_d    = req_write;
        addr_d  = req_addr;
        data_d  = req_data;
        err_d   = 1'b0;
        state_d = ST_START;
      end
      ST_START: state_d = ST_CYC;
      ST_CYC: begin
        state_d = ST_ADDR;
        idx_d   = 2'd0;
      end
      ST_ADDR: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          state_d = wr_q ? ST_WDATA : ST_TAR1;
        end
      end
      ST_WDATA: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd1) state_d = ST_TAR1;
      end
      ST_TAR1: state_d = ST_TAR2;
      ST_TAR2: begin
        state_d = ST_SYNC;
        cnt_d   = '0;
      end
      ST_SYNC: begin
        case (LAD_I)
          SYNC_READY, SYNC_ERROR: begin
            err_d   = (LAD_I == SYNC_ERROR);
            idx_d   = 2'd0;
            state_d = wr_q ? ST_PTAR : ST_RDATA;
          end
          SYNC_LONG_WAIT: cnt_d = '0;
          default: begin
            // short wait, and anything unrecognised (incl. a floating bus)
            cnt_d = cnt_inc;
            if (cnt_inc == TO_LIMIT) begin
`ifdef LPC_HOST_ABORT_EN
              idx_d   = 2'd0;
              state_d = ST_ABORT;
`else
              state_d     = ST_IDLE;
              rsp_valid_d = 1'b1;
              rsp_error_d = 1'b1;
              rsp_data_d  = 8'hFF;
`endif
            end
          end
        endcase
      end
      ST_RDATA: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd0) begin
          rdata_d[3:0] = LAD_I;
        end else begin
          rdata_d[7:4] = LAD_I;
          idx_d        = 2'd0;
          state_d      = ST_PTAR;
        end
      end
      ST_PTAR: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd1) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_error_d = err_q;
          if (!wr_q) rsp_data_d = rdata_q;
        end
      end
      ST_ABORT: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_ABORT_END;
      end
      ST_ABORT_END: begin
        // ABORT is only reachable through a SYNC timeout
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b1;
        rsp_data_d  = 8'hFF;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pad outputs are decoded from the next state so they line up with state_q.
    frame_d  = 1'b1;
    lad_o_d  = LAD_IDLE;
    lad_oe_d = 1'b0;
    case (state_d)
      ST_START: begin
        frame_d  = 1'b0;
        lad_o_d  = LPC_START;
        lad_oe_d = 1'b1;
      end
      ST_CYC: begin
        lad_o_d  = wr_d ? CYC_IO_WR : CYC_IO_RD;
        lad_oe_d = 1'b1;
      end
      ST_ADDR: begin
        lad_oe_d = 1'b1;
        case (idx_d)
          2'd0:    lad_o_d = addr_d[15:12];
          2'd1:    lad_o_d = addr_d[11:8];
          2'd2:    lad_o_d = addr_d[7:4];
          default: lad_o_d = addr_d[3:0];
        endcase
      end
      ST_WDATA: begin
        lad_oe_d = 1'b1;
        lad_o_d  = (idx_d == 2'd0) ? data_d[3:0] : data_d[7:4];
      end
      ST_TAR1: lad_oe_d = 1'b1;
      ST_ABORT: begin
        frame_d  = 1'b0;
        lad_oe_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge LPC_CLK) begin
    if (LPC_RST) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      frame_q     <= 1'b1;
      lad_o_q     <= LAD_IDLE;
      lad_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      frame_q     <= frame_d;
      lad_o_q     <= lad_o_d;
      lad_oe_q    <= lad_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign LPC_FRAME = frame_q;
  assign LAD_O     = lad_o_q;
  assign LAD_OE    = lad_oe_q;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_lpc_host.sv
// Directed bench for lpc_host: scripted target drives SYNC/data on LAD_I by
// cycle number after acceptance; timing, pad behaviour and responses are checked.
module tb_lpc_host;

`ifdef LPC_HOST_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic        LPC_CLK = 1'b0;
  logic        LPC_RST = 1'b1;
  logic        LPC_FRAME;
  logic [3:0]  LAD_O;
  logic        LAD_OE;
  logic [3:0]  LAD_I = 4'hF;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_data = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_error;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] t1_lad [9];

  lpc_host #(.SYNC_TIMEOUT(8)) dut (
    .LPC_CLK(LPC_CLK), .LPC_RST(LPC_RST), .LPC_FRAME(LPC_FRAME),
    .LAD_O(LAD_O), .LAD_OE(LAD_OE), .LAD_I(LAD_I),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error)
  );

  always #5 LPC_CLK = ~LPC_CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issue one request at the current negedge and play the target script.
  // Cycle Tk is the k-th clock after the accepting edge.
  task automatic run_xfer(input string name, input logic wr, input logic [15:0] addr,
                          input logic [7:0] wdata, input int nwait, input logic [3:0] wcode,
                          input logic [3:0] fcode, input logic tgt, input logic [7:0] rdata,
                          input int exp_lat, input logic exp_err, input logic [7:0] exp_data,
                          input int quiet_end, input bit seq1, input bit abort_chk);
    int s;
    int lat;
    logic [3:0] lad;
    logic drv;
    s   = wr ? 11 : 9;
    lat = -1;
    check({name, "_ready_in"}, req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_data = wdata;
    @(posedge LPC_CLK);
    for (int k = 1; k <= 60; k++) begin
      @(negedge LPC_CLK);
      if (k == 1) begin
        req_valid = 1'b0; req_write = ~wr; req_addr = ~addr; req_data = ~wdata;
      end
      if (rsp_valid) begin
        lat = k;
        break;
      end
      lad = 4'hF; drv = 1'b0;
      if (k >= s && k < s + nwait)        begin lad = wcode;      drv = tgt; end
      else if (k == s + nwait)            begin lad = fcode;      drv = tgt; end
      else if (!wr && k == s + nwait + 1) begin lad = rdata[3:0]; drv = tgt; end
      else if (!wr && k == s + nwait + 2) begin lad = rdata[7:4]; drv = tgt; end
      LAD_I = lad;
      if ((k >= s - 1 && k <= quiet_end) || drv) check({name, "_oe_quiet"}, LAD_OE, 0);
      if (seq1) begin
        check({name, "_frame"}, LPC_FRAME, (k != 1));
        if (k <= 9) begin
          check({name, "_lad"}, LAD_O, t1_lad[k-1]);
          check({name, "_oe_drv"}, LAD_OE, 1);
        end
      end
      if (abort_chk && k >= 17 && k <= 20) begin
        check({name, "_abort_frame"}, LPC_FRAME, 0);
        check({name, "_abort_lad"}, LAD_O, 4'hF);
        check({name, "_abort_oe"}, LAD_OE, 1);
      end
      if (abort_chk && k == 21) begin
        check({name, "_abort_end_frame"}, LPC_FRAME, 1);
        check({name, "_abort_end_oe"}, LAD_OE, 0);
      end
    end
    LAD_I = 4'hF;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_rsp_error"}, rsp_error, exp_err);
    check({name, "_rsp_data"}, rsp_data, exp_data);
    check({name, "_ready_out"}, req_ready, 1);
  endtask

  initial begin
    int seen;
    t1_lad = '{4'h0, 4'h2, 4'h0, 4'h3, 4'hF, 4'h8, 4'h1, 4'h4, 4'hF};
    repeat (2) @(negedge LPC_CLK);
    check("rst_frame", LPC_FRAME, 1);
    check("rst_oe", LAD_OE, 0);
    check("rst_lad", LAD_O, 4'hF);
    check("rst_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_error", rsp_error, 0);
    LPC_RST = 1'b0;
    @(negedge LPC_CLK);

    run_xfer("wr_fast", 1, 16'h03F8, 8'h41, 0, 4'h0, 4'h0, 1, 8'h00, 14, 0, 8'h00, 13, 1, 0);
    run_xfer("rd_short", 0, 16'h03FD, 8'h00, 3, 4'h5, 4'h0, 1, 8'h60, 17, 0, 8'h60, 16, 0, 0);
    run_xfer("rd_long", 0, 16'h03FD, 8'h00, 20, 4'h6, 4'h0, 1, 8'hA5, 34, 0, 8'hA5, 33, 0, 0);
    run_xfer("rd_timeout", 0, 16'h03FE, 8'h00, 100, 4'hF, 4'hF, 0, 8'h00,
             ABORT ? 22 : 17, 1, 8'hFF, 16, 0, ABORT);
    run_xfer("wr_syncerr", 1, 16'h03F9, 8'h55, 0, 4'h0, 4'hA, 1, 8'h00, 14, 1, 8'hFF, 13, 0, 0);
    run_xfer("rd_b2b", 0, 16'h0060, 8'h00, 0, 4'h0, 4'h0, 1, 8'h3C, 14, 0, 8'h3C, 13, 0, 0);
    run_xfer("rd_syncerr", 0, 16'h0061, 8'h00, 0, 4'h0, 4'hA, 1, 8'h7E, 14, 1, 8'h7E, 13, 0, 0);

    // Reset in the middle of the address phase.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h03F8;
    @(posedge LPC_CLK);
    for (int k = 1; k <= 4; k++) begin
      @(negedge LPC_CLK);
      if (k == 1) req_valid = 1'b0;
    end
    LPC_RST = 1'b1;
    @(negedge LPC_CLK);
    LPC_RST = 1'b0;
    check("midrst_frame", LPC_FRAME, 1);
    check("midrst_oe", LAD_OE, 0);
    check("midrst_lad", LAD_O, 4'hF);
    check("midrst_ready", req_ready, 1);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) seen++;
      @(negedge LPC_CLK);
    end
    check("midrst_no_rsp", seen, 0);
    run_xfer("rd_after_rst", 0, 16'h03FB, 8'h00, 0, 4'h0, 4'h0, 1, 8'hC3, 14, 0, 8'hC3, 13, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
